sift_stage_sched: RTL
=====================

Name: sift_stage_sched

Overview:
Top-level sequencer for the SIFT front end inside CORE.
- Walks the four Gaussian blur passes row by row over the 640x480 image (scales 0..3, each written to blur_img_0..3).
- Raises gaussian_done[s] per scale, then walks the extremum-detection pass and raises detect_filter_done.
- Allocates write addresses into keypoint_1_mem and keypoint_2_mem, each 2000 deep, 19-bit entries: [18:10] row, [9:0] col.

Parameters:
ROWS, 480, image rows
ROW_W, 9, row index width
NUM_SCALES, 4, blur passes
KPT_DEPTH, 2000, keypoint memory depth per layer
KPT_AW, 11, keypoint address width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  level; begins a frame when sampled high in IDLE or DONE
blur_req  out  1  row request to blur engine
blur_scale  out  2  scale of current request
blur_row  out  ROW_W  row of current request
blur_ack  in  1  blur engine accepts request
gaussian_done  out  NUM_SCALES  sticky per-scale completion
det_req  out  1  row request to detect filter
det_row  out  ROW_W  centre row for detection
det_ack  in  1  detect filter accepts request
detect_filter_done  out  1  sticky frame completion
kpt1_valid  in  1  layer-1 keypoint found this cycle
kpt2_valid  in  1  layer-2 keypoint found this cycle
kpt1_we  out  1  write enable, keypoint_1_mem
kpt2_we  out  1  write enable, keypoint_2_mem
kpt1_addr  out  KPT_AW  write address, layer 1
kpt2_addr  out  KPT_AW  write address, layer 2
kpt_overflow  out  2  sticky dropped-write flags {layer2, layer1}
busy  out  1  high outside IDLE/DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0. Reset mid-frame aborts immediately. No pending request survives reset.
- States: IDLE, BLUR, DET, DONE.
- IDLE/DONE + start=1 at clk edge:
  - go to BLUR; scale=0, row=0.
  - clear gaussian_done, detect_filter_done, kpt addresses, kpt_overflow.
  - start is ignored in BLUR/DET.
- Handshake (both channels): valid/ready.
  - req and its payload are registered and stay stable until a cycle with req&&ack.
  - Back-to-back transfers allowed: on a transfer the next request is presented in the following cycle with req still high.
  - ack with req low has no effect.
- BLUR:
  - blur_req=1, blur_scale=scale, blur_row=row.
  - On transfer with row<ROWS-1: row+1.
  - On transfer with row==ROWS-1: gaussian_done[scale] set next cycle.
    - scale<3: scale+1, row=0.
    - scale==3: go to DET with row=1.
- DET:
  - det_req=1, det_row=row; rows 1..ROWS-2 only (border rows skipped).
  - On transfer of row ROWS-2: detect_filter_done=1 next cycle; go to DONE; det_req=0.
- Latency with ack tied high:
  - first blur_req in the cycle after start sampled.
  - gaussian_done[s] rises (s+1)*480 cycles after first req.
  - detect_filter_done rises 1920+478 cycles after first req.
- Keypoint allocation (combinational enables, registered addresses), accepted only in DET and DONE-entry cycle:
  - kptN_we = kptN_valid && addrN<KPT_DEPTH && (state==DET).
  - kptN_addr is the address for the current write; increments by 1 after each we.
  - Full at addr==KPT_DEPTH (2000): further valids dropped, kpt_overflow[N-1] set sticky.
  - Simultaneous kpt1/kpt2 valids are independent and both accepted.
  - Valids outside DET are ignored; no overflow flag is set for them.
- busy = (state==BLUR || state==DET).

Decomposition:
- Package sift_pkg: ROWS, COLS (640), ROW_W, KPT_DEPTH, KPT_AW, NUM_SCALES, state enum.
- Sub-module kpt_alloc (one instance per layer): valid/enable, saturating address counter, sticky overflow.
- Top FSM and row/scale counters live in sift_stage_sched.

Test Plan:
1. Reset with rst_n=0 mid-BLUR (scale 2, row 100) -> next cycle all outputs 0, state IDLE; later start restarts from scale 0 row 0.
2. start=1, blur_ack and det_ack tied 1 -> blur_row sweeps 0..479 four times with scale 0..3; gaussian_done goes 0001, 0011, 0111, 1111 at 480-cycle intervals; det_row 1..478; detect_filter_done at cycle 2398 after first req.
3. blur_ack random 30% duty -> blur_row/blur_scale never change while blur_req high and ack low; the scoreboard counts exactly 1920 blur transfers, each (scale,row) pair exactly once.
4. In DET, kpt1_valid held high for 2005 cycles -> kpt1_we for 2000 cycles, addresses 0..1999, kpt1_addr parks at 2000, kpt_overflow=01; layer 2 unaffected.
5. kpt1_valid and kpt2_valid both pulsed in the same cycle during DET, and kpt1_valid pulsed during BLUR -> both DET writes accepted at address 0; the BLUR pulse produces no we and no overflow.
6. start held high through DONE -> new frame begins and clears all done/overflow flags; start toggled during BLUR -> ignored.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared constants and state encoding for the SIFT front-end stage scheduler.
package sift_pkg;

  localparam int unsigned ROWS       = 480;
  localparam int unsigned COLS       = 640;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned NUM_SCALES = 4;
  localparam int unsigned SCALE_W    = 2;
  localparam int unsigned KPT_DEPTH  = 2000;
  localparam int unsigned KPT_AW     = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BLUR = 2'd1,
    ST_DET  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/kpt_alloc.sv
// Keypoint write-address allocator for one layer: saturating address counter
// with a sticky flag for writes dropped once the memory is full.
module kpt_alloc
  import sift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              active_i,
  input  logic              valid_i,
  output logic              we_c,
  output logic [KPT_AW-1:0] addr_o,
  output logic              overflow_o
);

  logic [KPT_AW-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              full;

  assign full = (addr_q >= KPT_AW'(KPT_DEPTH));
  assign we_c = valid_i && active_i && !full;

  always_comb begin
    addr_d = addr_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      addr_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (we_c) addr_d = addr_q + KPT_AW'(1);
      if (valid_i && active_i && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign addr_o     = addr_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sift_stage_sched.sv
// SIFT front-end sequencer: four blur passes over all rows, then the
// extremum-detection pass over interior rows, plus keypoint address allocation.
module sift_stage_sched
  import sift_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  blur_req,
  output logic [SCALE_W-1:0]    blur_scale,
  output logic [ROW_W-1:0]      blur_row,
  input  logic                  blur_ack,
  output logic [NUM_SCALES-1:0] gaussian_done,
  output logic                  det_req,
  output logic [ROW_W-1:0]      det_row,
  input  logic                  det_ack,
  output logic                  detect_filter_done,
  input  logic                  kpt1_valid,
  input  logic                  kpt2_valid,
  output logic                  kpt1_we,
  output logic                  kpt2_we,
  output logic [KPT_AW-1:0]     kpt1_addr,
  output logic [KPT_AW-1:0]     kpt2_addr,
  output logic [1:0]            kpt_overflow,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic                    blur_req_q, blur_req_d;
  logic [SCALE_W-1:0]      scale_q, scale_d;
  logic [ROW_W-1:0]        blur_row_q, blur_row_d;
  logic                    det_req_q, det_req_d;
  logic [ROW_W-1:0]        det_row_q, det_row_d;
  logic [NUM_SCALES-1:0]   gdone_q, gdone_d;
  logic                    det_done_q, det_done_d;
  logic                    busy_q, busy_d;

  logic blur_xfer, det_xfer, start_frame;
  logic blur_last_row, last_scale, det_last_row;
  logic ovf1, ovf2;

  assign blur_xfer     = blur_req_q && blur_ack;
  assign det_xfer      = det_req_q && det_ack;
  assign start_frame   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign blur_last_row = (blur_row_q == ROW_W'(ROWS - 1));
  assign last_scale    = (scale_q == SCALE_W'(NUM_SCALES - 1));
  assign det_last_row  = (det_row_q == ROW_W'(ROWS - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      blur_req_q <= 1'b0;
      scale_q    <= '0;
      blur_row_q <= '0;
      det_req_q  <= 1'b0;
      det_row_q  <= '0;
      gdone_q    <= '0;
      det_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blur_req_q <= blur_req_d;
      scale_q    <= scale_d;
      blur_row_q <= blur_row_d;
      det_req_q  <= det_req_d;
      det_row_q  <= det_row_d;
      gdone_q    <= gdone_d;
      det_done_q <= det_done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_BLUR;
      ST_BLUR: if (blur_xfer && blur_last_row && last_scale) state_d = ST_DET;
      ST_DET:  if (det_xfer && det_last_row) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered request/payload and completion flags for the next cycle.
  always_comb begin
    blur_req_d = blur_req_q;
    scale_d    = scale_q;
    blur_row_d = blur_row_q;
    det_req_d  = det_req_q;
    det_row_d  = det_row_q;
    gdone_d    = gdone_q;
    det_done_d = det_done_q;
    if (start_frame) begin
      blur_req_d = 1'b1;
      scale_d    = '0;
      blur_row_d = '0;
      gdone_d    = '0;
      det_done_d = 1'b0;
    end else if ((state_q == ST_BLUR) && blur_xfer) begin
      if (blur_last_row) begin
        gdone_d[scale_q] = 1'b1;
        blur_row_d       = '0;
        if (last_scale) begin
          blur_req_d = 1'b0;
          scale_d    = '0;
          det_req_d  = 1'b1;
          det_row_d  = ROW_W'(1);
        end else begin
          scale_d = scale_q + SCALE_W'(1);
        end
      end else begin
        blur_row_d = blur_row_q + ROW_W'(1);
      end
    end else if ((state_q == ST_DET) && det_xfer) begin
      if (det_last_row) begin
        det_req_d  = 1'b0;
        det_done_d = 1'b1;
      end else begin
        det_row_d = det_row_q + ROW_W'(1);
      end
    end
    busy_d = (state_d == ST_BLUR) || (state_d == ST_DET);
  end

  kpt_alloc u_kpt1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_frame),
    .active_i   (state_q == ST_DET),
    .valid_i    (kpt1_valid),
    .we_c       (kpt1_we),
    .addr_o     (kpt1_addr),
    .overflow_o (ovf1)
  );

  kpt_alloc u_kpt2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_frame),
    .active_i   (state_q == ST_DET),
    .valid_i    (kpt2_valid),
    .we_c       (kpt2_we),
    .addr_o     (kpt2_addr),
    .overflow_o (ovf2)
  );

  assign blur_req           = blur_req_q;
  assign blur_scale         = scale_q;
  assign blur_row           = blur_row_q;
  assign det_req            = det_req_q;
  assign det_row            = det_row_q;
  assign gaussian_done      = gdone_q;
  assign detect_filter_done = det_done_q;
  assign kpt_overflow       = {ovf2, ovf1};
  assign busy               = busy_q;

endmodule
